// File: rtl/dot_timing_gen.sv
// dot_timing_gen: emits NPIX evenly spaced pixel strobes across each sync-started scan line.
// Define DOTGEN_OFFSET_EN to add per-direction start offsets (ofs_ltr/ofs_rtl ports).
module dot_timing_gen #(
  parameter int NPIX       = 1024,
  parameter int ADDR_W     = 10,
  parameter int MIN_PERIOD = 2048
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              sync_start,
  input  logic              scan_dir,
  input  logic [31:0]       t_ltr,
  input  logic [31:0]       t_rtl,
`ifdef DOTGEN_OFFSET_EN
  input  logic [15:0]       ofs_ltr,
  input  logic [15:0]       ofs_rtl,
`endif
  output logic              pix_strobe,
  output logic [ADDR_W-1:0] pix_addr,
  output logic              line_active,
  output logic              line_dir,
  output logic              line_done,
  output logic              overrun,
  output logic              bad_period
);
`ifdef DOTGEN_OFFSET_EN
  typedef enum logic [1:0] {IDLE, RUN, OFFSET} state_t;
  logic [15:0] ofs_q, o_sel;
`else
  typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NPIX - 1);
  state_t            state_q;
  logic              sync_prev_q, bad_pend_q, ovr_pend_q;
  logic              strobe_q, active_q, dir_q, done_q, ovr_q, bad_q;
  logic [31:0]       p_q, acc_q, acc_d, p_sel;
  logic [ADDR_W-1:0] k_q, addr_q, addr_d;
  logic [32:0]       sum;
  logic              start, bad, hit;
  assign start  = sync_start & ~sync_prev_q & enable;
  assign p_sel  = scan_dir ? t_rtl : t_ltr;
  assign bad    = p_sel < 32'(MIN_PERIOD);
  assign sum    = {1'b0, acc_q} + 33'(NPIX);
  assign hit    = sum >= {1'b0, p_q};
  // wraps in 32 bits; the true remainder is always below P
  assign acc_d  = (acc_q + 32'(NPIX)) - (hit ? p_q : 32'd0);
  assign addr_d = dir_q ? LAST - k_q : k_q;
`ifdef DOTGEN_OFFSET_EN
  assign o_sel  = scan_dir ? ofs_rtl : ofs_ltr;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      sync_prev_q <= 1'b0;
      bad_pend_q  <= 1'b0;
      ovr_pend_q  <= 1'b0;
      strobe_q    <= 1'b0;
      active_q    <= 1'b0;
      dir_q       <= 1'b0;
      done_q      <= 1'b0;
      ovr_q       <= 1'b0;
      bad_q       <= 1'b0;
      p_q         <= '0;
      acc_q       <= '0;
      k_q         <= '0;
      addr_q      <= '0;
`ifdef DOTGEN_OFFSET_EN
      ofs_q       <= '0;
`endif
    end else begin
      sync_prev_q <= sync_start;
      bad_pend_q  <= start & bad;
      ovr_pend_q  <= start & (state_q != IDLE);
      bad_q       <= bad_pend_q;
      ovr_q       <= ovr_pend_q;
      active_q    <= state_q != IDLE;
      strobe_q    <= 1'b0;
      done_q      <= 1'b0;
      if (start) begin
        if (bad) begin
          state_q <= IDLE;
        end else begin
          p_q   <= p_sel;
          dir_q <= scan_dir;
          acc_q <= '0;
          k_q   <= '0;
`ifdef DOTGEN_OFFSET_EN
          ofs_q   <= o_sel;
          state_q <= (o_sel == 16'd0) ? RUN : OFFSET;
`else
          state_q <= RUN;
`endif
        end
      end else if (state_q == RUN) begin
        acc_q <= acc_d;
        if (hit) begin
          k_q      <= k_q + 1'b1;
          strobe_q <= 1'b1;
          addr_q   <= addr_d;
          done_q   <= k_q == LAST;
          if (k_q == LAST) state_q <= IDLE;
        end
      end
`ifdef DOTGEN_OFFSET_EN
      else if (state_q == OFFSET) begin
        ofs_q <= ofs_q - 16'd1;
        if (ofs_q == 16'd1) state_q <= RUN;
      end
`endif
    end
  end
  assign pix_strobe  = strobe_q;
  assign pix_addr    = addr_q;
  assign line_active = active_q;
  assign line_dir    = dir_q;
  assign line_done   = done_q;
  assign overrun     = ovr_q;
  assign bad_period  = bad_q;
endmodule
